uart_bist_controller: RTL
=========================

# uart_bist_controller

Sequencer for the UART built-in self-test loopback. It takes a start request and drives `op_mode` and the LFSR seed strobe (`temp`) into the LFSR → mux → UART_rx → UART_tx → demux path. It counts baud ticks through a settle window and a measurement window, compacts the returned serial stream into a 16-bit MISR signature, and reports pass or fail against a supplied golden signature. It replaces the free-running comparator/response_analyzer pair with a bounded, restartable test.

## Interface
- `TEST_BITS`, default 67: number of baud ticks compacted in RUN; legal range 1..127.
- `SETTLE_TICKS`, default 4: baud ticks skipped after seeding, to cover LFSR/RX/TX pipeline latency; legal range 0..15.
- `clk`, in, 1: system clock (66 MHz domain of the baud generator).
- `rst`, in, 1: asynchronous, active-high reset.
- `baud_tick`, in, 1: one-`clk` pulse per bit period, from the baud generator.
- `start`, in, 1: test request; sampled only in IDLE.
- `abort`, in, 1: cancels a running test.
- `loop_in`, in, 1: serial stream returned from TX through the demux test leg.
- `expected_sig`, in, 16: golden signature; sampled in CHECK.
- `op_mode`, out, 1: selects LFSR source and test leg; high in every state except IDLE.
- `seed_load`, out, 1: drives LFSR `temp`; high only in SEED.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-`clk` pulse on completion.
- `pass`, out, 1: result flag, held until the next accepted start, abort or reset.
- `fail`, out, 1: result flag, held under the same rules as `pass`.
- `signature`, out, 16: current MISR value.
- `bit_count`, out, 7: ticks compacted so far in RUN.

## Operation
- States: IDLE, SEED, SETTLE, RUN, CHECK, DONE.
- IDLE: `op_mode` = 0.
  - `start` & !`abort` → SEED.
  - Entering SEED clears `pass`, `fail`, `bit_count` and the settle counter, and loads MISR = 16'hFFFF.
- SEED: `seed_load` = 1 until the first `baud_tick`, which moves the state to SETTLE. This holds the seed for a full LFSR clock edge.
- SETTLE: counts `baud_tick`. After SETTLE_TICKS ticks → RUN. With SETTLE_TICKS = 0, go directly SEED → RUN.
- RUN: on each `baud_tick`:
  - MISR shifts: fb = sig[15] ^ `loop_in`; sig ← {sig[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - `bit_count` increments.
  - The tick that makes `bit_count` = TEST_BITS → CHECK.
- CHECK: single `clk`.
  - `pass` ← (sig == `expected_sig`); `fail` ← !that.
  - → DONE.
- DONE: `done` = 1 for one `clk` → IDLE.
- `abort` in any non-IDLE state → IDLE next `clk`. `pass` = `fail` = 0, no `done`, MISR and `bit_count` frozen.
- `start` outside IDLE is ignored. `abort` has priority over `start` and over tick handling.
- `baud_tick` is ignored in IDLE, CHECK and DONE.
- Mid-test `rst` returns everything to reset values immediately.

## Timing
- Reset values:
  - State IDLE.
  - `op_mode`, `seed_load`, `busy`, `done`, `pass`, `fail` = 0.
  - `signature` = 16'hFFFF.
  - `bit_count` = 0.
- All outputs are registered.
- Sequence timing:
  - `start` sampled at edge n → `busy`, `op_mode`, `seed_load` high after edge n.
  - `seed_load` falls on the edge sampling the first `baud_tick`.
- Results:
  - `pass`/`fail` valid the edge after CHECK.
  - `done` coincides with the first cycle in which `pass`/`fail` are valid.
  - `busy` falls together with `done`.
- Total latency: start → done = (SEED wait) + SETTLE_TICKS + TEST_BITS baud periods + 2 `clk`.
- Width rules:
  - `bit_count` never wraps (TEST_BITS ≤ 127).
  - The settle counter is 4 bits.

## Structure
- Package `bist_pkg`: state enum; MISR_POLY = 16'h1021; MISR_INIT = 16'hFFFF.
- Sub-module `bist_misr`:
  - Ports: clk, rst, init, shift_en, din, sig[15:0].
  - Instantiated once.
  - Reusable for a future parallel-data BIST.

## Test plan
- TEST_BITS = 8, SETTLE_TICKS = 0, `loop_in` = 0, `expected_sig` = 16'hE1F0, `start` pulse → `signature` = 16'hE1F0, `pass` = 1, `fail` = 0, `done` pulses once, `busy` low after.
- Same setup, `expected_sig` = 16'h0000 → `fail` = 1, `pass` = 0; both held until the next `start`.
- SETTLE_TICKS = 4, `loop_in` toggling → MISR unchanged for the first 4 ticks after SEED; `bit_count` reaches 8 exactly on the 12th post-seed tick.
- `abort` after 3 RUN ticks → IDLE next `clk`, `op_mode` = 0, `pass` = `fail` = 0, no `done`, `bit_count` = 3 frozen.
- `start` during RUN is ignored. `start` & `abort` in IDLE → stays IDLE. `seed_load` stays high across 100 `clk` with no `baud_tick`.
- Async `rst` pulse mid-RUN, between `clk` edges → all outputs at reset values immediately; a later `start` runs a clean test to `pass`.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and constants for the UART loopback self-test sequencer.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_SETTLE,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } bist_state_e;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_INIT = 16'hFFFF;

  // One serial compaction step: CCITT polynomial with the new bit folded into the feedback.
  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic din);
    logic fb;
    fb = sig[15] ^ din;
    return {sig[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/bist_misr.sv
// 16-bit serial-input signature register; init takes priority over shift.
module bist_misr
  import bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        shift_en,
  input  logic        din,
  output logic [15:0] sig
);

  logic [15:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (init) begin
      sig_d = MISR_INIT;
    end else if (shift_en) begin
      sig_d = misr_step(sig_q, din);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= MISR_INIT;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/uart_bist_controller.sv
// Bounded, restartable UART loopback self-test: seeds the LFSR, waits out the
// pipeline, compacts TEST_BITS returned bits into a MISR and grades the result.
module uart_bist_controller
  import bist_pkg::*;
#(
  parameter int TEST_BITS    = 67,
  parameter int SETTLE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        baud_tick,
  input  logic        start,
  input  logic        abort,
  input  logic        loop_in,
  input  logic [15:0] expected_sig,
  output logic        op_mode,
  output logic        seed_load,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [15:0] signature,
  output logic [6:0]  bit_count
);

  localparam logic [6:0] TEST_BITS_C    = 7'(TEST_BITS);
  localparam logic [3:0] SETTLE_TICKS_C = 4'(SETTLE_TICKS);

  bist_state_e state_q, state_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic [6:0]  bit_count_q, bit_count_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        done_q, done_d;
  logic        op_mode_q, op_mode_d;
  logic        seed_load_q, seed_load_d;
  logic        busy_q, busy_d;
  logic        misr_init, misr_shift;
  logic [15:0] sig;

  bist_misr u_misr (
    .clk      (clk),
    .rst      (rst),
    .init     (misr_init),
    .shift_en (misr_shift),
    .din      (loop_in),
    .sig      (sig)
  );

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    bit_count_d  = bit_count_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    misr_init    = 1'b0;
    misr_shift   = 1'b0;

    // Abort outranks both start and tick handling; counters and MISR stay frozen.
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_d      = ST_SEED;
            pass_d       = 1'b0;
            fail_d       = 1'b0;
            bit_count_d  = '0;
            settle_cnt_d = '0;
            misr_init    = 1'b1;
          end else if (abort) begin
            pass_d = 1'b0;
            fail_d = 1'b0;
          end
        end
        ST_SEED: begin
          if (baud_tick) begin
            state_d = (SETTLE_TICKS_C == 4'd0) ? ST_RUN : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (baud_tick) begin
            settle_cnt_d = settle_cnt_q + 4'd1;
            if (settle_cnt_d == SETTLE_TICKS_C) begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (baud_tick) begin
            misr_shift  = 1'b1;
            bit_count_d = bit_count_q + 7'd1;
            if (bit_count_d == TEST_BITS_C) begin
              state_d = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          pass_d  = (sig == expected_sig);
          fail_d  = (sig != expected_sig);
          state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    op_mode_d   = (state_d != ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    seed_load_d = (state_d == ST_SEED);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      bit_count_q  <= '0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      done_q       <= 1'b0;
      op_mode_q    <= 1'b0;
      seed_load_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      bit_count_q  <= bit_count_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      done_q       <= done_d;
      op_mode_q    <= op_mode_d;
      seed_load_q  <= seed_load_d;
      busy_q       <= busy_d;
    end
  end

  assign op_mode   = op_mode_q;
  assign seed_load = seed_load_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign signature = sig;
  assign bit_count = bit_count_q;

endmodule
